// File: rtl/toy_cipher_round_ctrl.sv
// Iterative round controller for the 4-bit toy cipher: owns state/key/round registers around an external S-box/key-add stage.
// Optional temporal-redundancy round check enabled by defining DUPLICATE_ROUND_CHECK_EN.
module toy_cipher_round_ctrl #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [3:0]  io_in_plaintext,
  input  logic [15:0] io_in_key,
  output logic [3:0]  io_sbox_state,
  output logic [3:0]  io_sbox_key,
  input  logic [3:0]  io_sbox_out,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [3:0]  io_out_ciphertext,
  output logic        io_fault
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
`ifdef DUPLICATE_ROUND_CHECK_EN
  localparam logic [1:0] S_RUN_CHK = 2'd3;
`endif

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  logic [1:0]  state_q, state_d;
  logic [3:0]  st_q, st_d;
  logic [15:0] key_q, key_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        run_active;
  logic [3:0]  round_key;
`ifdef DUPLICATE_ROUND_CHECK_EN
  logic [3:0]  tmp_q, tmp_d;
  logic        fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
`ifdef DUPLICATE_ROUND_CHECK_EN
    tmp_d   = tmp_q;
    fault_d = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (io_in_valid) begin
          // Whitening with key nibble 0 happens on the accepting edge
          st_d    = io_in_plaintext ^ io_in_key[3:0];
          key_d   = io_in_key;
          rnd_d   = 4'd1;
`ifdef DUPLICATE_ROUND_CHECK_EN
          fault_d = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
`ifdef DUPLICATE_ROUND_CHECK_EN
        tmp_d   = io_sbox_out;
        state_d = S_RUN_CHK;
`else
        st_d = io_sbox_out;
        if (rnd_q == LAST_RND) begin
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
`endif
      end
`ifdef DUPLICATE_ROUND_CHECK_EN
      S_RUN_CHK: begin
        // Second evaluation of the same round must reproduce the first
        if (io_sbox_out == tmp_q) begin
          st_d = io_sbox_out;
          if (rnd_q == LAST_RND) begin
            state_d = S_DONE;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = S_RUN;
          end
        end else begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (io_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

`ifdef DUPLICATE_ROUND_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmp_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmp_q   <= tmp_d;
      fault_q <= fault_d;
    end
  end
`endif

  // Round r uses key nibble (r mod 4)
  always_comb begin
    round_key = '0;
    case (rnd_q[1:0])
      2'd0: round_key = key_q[3:0];
      2'd1: round_key = key_q[7:4];
      2'd2: round_key = key_q[11:8];
      2'd3: round_key = key_q[15:12];
      default: round_key = '0;
    endcase
  end

  always_comb begin
    run_active = (state_q == S_RUN);
`ifdef DUPLICATE_ROUND_CHECK_EN
    run_active = run_active || (state_q == S_RUN_CHK);
`endif
    io_in_ready       = (state_q == S_IDLE);
    io_out_valid      = (state_q == S_DONE);
    io_sbox_state     = run_active ? st_q : '0;
    io_sbox_key       = run_active ? round_key : '0;
    io_out_ciphertext = (state_q == S_DONE) ? st_q : '0;
`ifdef DUPLICATE_ROUND_CHECK_EN
    io_fault          = fault_q;
    if (fault_q) begin
      io_out_ciphertext = '0;
    end
`else
    io_fault          = 1'b0;
`endif
  end

endmodule

// File: tb/tb_toy_cipher_round_ctrl.sv
// Self-checking bench for toy_cipher_round_ctrl: behavioural S-box stage plus ciphertext scoreboard.
module tb_toy_cipher_round_ctrl;

  localparam int unsigned ROUNDS = 4;
`ifdef DUPLICATE_ROUND_CHECK_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif
  localparam int unsigned LAT = ROUNDS * STEP;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [3:0]  io_in_plaintext;
  logic [15:0] io_in_key;
  logic [3:0]  io_sbox_state;
  logic [3:0]  io_sbox_key;
  logic [3:0]  io_sbox_out;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [3:0]  io_out_ciphertext;
  logic        io_fault;
  logic        flip;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [3:0]  exp_q[$];

  toy_cipher_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_plaintext(io_in_plaintext), .io_in_key(io_in_key),
    .io_sbox_state(io_sbox_state), .io_sbox_key(io_sbox_key), .io_sbox_out(io_sbox_out),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_ciphertext(io_out_ciphertext), .io_fault(io_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h0;  4'h1: sbox = 4'h3;  4'h2: sbox = 4'hE;  4'h3: sbox = 4'h9;
      4'h4: sbox = 4'h6;  4'h5: sbox = 4'hD;  4'h6: sbox = 4'h1;  4'h7: sbox = 4'hA;
      4'h8: sbox = 4'hF;  4'h9: sbox = 4'h8;  4'hA: sbox = 4'h4;  4'hB: sbox = 4'hB;
      4'hC: sbox = 4'h2;  4'hD: sbox = 4'h5;  4'hE: sbox = 4'hC;  default: sbox = 4'h7;
    endcase
  endfunction

  assign io_sbox_out = sbox(io_sbox_state) ^ io_sbox_key ^ {3'b000, flip};

  function automatic logic [3:0] model(input logic [3:0] pt, input logic [15:0] k);
    logic [3:0] s;
    s = pt ^ k[3:0];
    for (int unsigned r = 1; r <= ROUNDS; r++) begin
      s = sbox(s) ^ k[4*(r%4) +: 4];
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one block for exactly one edge and record its expected ciphertext
  task automatic accept(input logic [3:0] pt, input logic [15:0] k);
    io_in_plaintext = pt;
    io_in_key       = k;
    io_in_valid     = 1'b1;
    exp_q.push_back(model(pt, k));
    tick();
    io_in_valid     = 1'b0;
    io_in_plaintext = 4'($urandom);
    io_in_key       = 16'($urandom);
  endtask

  task automatic wait_valid(output int unsigned edges, output bit timeout);
    edges   = 0;
    timeout = 1'b0;
    while (!io_out_valid && !timeout) begin
      tick();
      edges++;
      if (edges > 200) timeout = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    reset = 1'b0;
    io_in_valid = 1'b0; io_in_plaintext = '0; io_in_key = '0;
    io_out_ready = 1'b1; flip = 1'b0;
    #12;
    obs = {io_in_ready, io_out_valid, io_out_ciphertext, io_sbox_state, io_sbox_key, io_fault};
    n_total++;
    if (obs !== 15'h4000) $display("FAIL reset_outputs: got %h expected %h", obs, 15'h4000);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    tick();
    obs = {io_in_ready, io_out_valid, io_out_ciphertext, io_sbox_state, io_sbox_key, io_fault};
    n_total++;
    if (obs !== 15'h4000) $display("FAIL idle_after_reset: got %h expected %h", obs, 15'h4000);
    else n_pass++;
  endtask

  task automatic test_zero_key();
    logic [3:0] exp;
    accept(4'h0, 16'h0000);
    for (int unsigned c = 0; c < LAT; c++) begin
      if (c % STEP == 0) begin
        n_total++;
        if (io_sbox_key !== 4'h0 || io_out_valid !== 1'b0)
          $display("FAIL zero_key_round%0d: key %h valid %b expected key 0 valid 0", c / STEP + 1, io_sbox_key, io_out_valid);
        else n_pass++;
      end
      tick();
    end
    exp = exp_q.pop_front();
    n_total++;
    if (io_out_valid !== 1'b1 || io_out_ciphertext !== exp)
      $display("FAIL zero_key_result: valid %b ct %h expected valid 1 ct %h", io_out_valid, io_out_ciphertext, exp);
    else n_pass++;
    tick();
  endtask

  task automatic test_key_1031();
    logic [3:0] exp_st[4];
    logic [3:0] exp_k[4];
    logic [3:0] exp;
    exp_st = '{4'h1, 4'h0, 4'h0, 4'h1};
    exp_k  = '{4'h3, 4'h0, 4'h1, 4'h1};
    accept(4'h0, 16'h1031);
    for (int unsigned c = 0; c < LAT; c++) begin
      if (c % STEP == 0) begin
        n_total++;
        if (io_sbox_state !== exp_st[c / STEP] || io_sbox_key !== exp_k[c / STEP])
          $display("FAIL seq_round%0d: state %h key %h expected state %h key %h",
                   c / STEP + 1, io_sbox_state, io_sbox_key, exp_st[c / STEP], exp_k[c / STEP]);
        else n_pass++;
      end
      tick();
    end
    exp = exp_q.pop_front();
    n_total++;
    if (io_out_valid !== 1'b1 || io_out_ciphertext !== 4'h2 || exp !== 4'h2)
      $display("FAIL key1031_result: valid %b ct %h expected valid 1 ct 2 (model %h)", io_out_valid, io_out_ciphertext, exp);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    int unsigned edges;
    bit          to;
    bit          stable;
    logic [3:0]  exp;
    io_out_ready = 1'b0;
    accept(4'h0, 16'h1031);
    io_in_valid = 1'b1; io_in_plaintext = 4'hF; io_in_key = 16'hFFFF;
    n_total++;
    if (io_in_ready !== 1'b0) $display("FAIL ready_in_run: got %b expected 0", io_in_ready);
    else n_pass++;
    wait_valid(edges, to);
    n_total++;
    if (to || edges != LAT) $display("FAIL bp_latency: got %0d edges (timeout %0d) expected %0d", edges, to, LAT);
    else n_pass++;
    exp = exp_q.pop_front();
    stable = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      if (io_out_valid !== 1'b1 || io_out_ciphertext !== exp || io_in_ready !== 1'b0) stable = 1'b0;
      tick();
    end
    n_total++;
    if (!stable || io_out_ciphertext !== 4'h2)
      $display("FAIL bp_hold: stable %b ct %h expected stable 1 ct 2", stable, io_out_ciphertext);
    else n_pass++;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    tick();
    n_total++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL bp_release: ready %b valid %b queued %0d expected ready 1 valid 0 queued 0",
               io_in_ready, io_out_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int unsigned edges;
    bit          to;
    logic [14:0] obs;
    logic [3:0]  exp;
    accept(4'h0, 16'h1031);
    for (int unsigned c = 0; c < STEP; c++) tick();
    n_total++;
    if (io_in_ready !== 1'b0 || io_sbox_key !== 4'h0 || io_sbox_state !== 4'h0)
      $display("FAIL round2_before_reset: ready %b state %h key %h expected ready 0 state 0 key 0",
               io_in_ready, io_sbox_state, io_sbox_key);
    else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    obs = {io_in_ready, io_out_valid, io_out_ciphertext, io_sbox_state, io_sbox_key, io_fault};
    n_total++;
    if (obs !== 15'h4000) $display("FAIL async_reset: got %h expected %h", obs, 15'h4000);
    else n_pass++;
    exp_q.delete();
    #2;
    reset = 1'b1;
    tick();
    accept(4'h5, 16'hA7C3);
    wait_valid(edges, to);
    exp = exp_q.pop_front();
    n_total++;
    if (to || edges != LAT || io_out_ciphertext !== exp)
      $display("FAIL post_reset_block: ct %h edges %0d expected ct %h edges %0d", io_out_ciphertext, edges, exp, LAT);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned edges;
    bit          to;
    logic [3:0]  exp;
    for (int unsigned i = 0; i < 6; i++) begin
      accept(4'($urandom), 16'($urandom));
      wait_valid(edges, to);
      exp = exp_q.pop_front();
      n_total++;
      if (to || edges != LAT) $display("FAIL b2b_latency%0d: got %0d edges expected %0d", i, edges, LAT);
      else n_pass++;
      n_total++;
      if (io_out_ciphertext !== exp || io_fault !== 1'b0)
        $display("FAIL b2b_ct%0d: ct %h fault %b expected ct %h fault 0", i, io_out_ciphertext, io_fault, exp);
      else n_pass++;
      tick();
      n_total++;
      if (io_in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b expected 1", i, io_in_ready);
      else n_pass++;
    end
  endtask

`ifdef DUPLICATE_ROUND_CHECK_EN
  task automatic test_fault();
    int unsigned edges;
    bit          to;
    logic [3:0]  exp;
    accept(4'h0, 16'h1031);
    wait_valid(edges, to);
    exp = exp_q.pop_front();
    n_total++;
    if (to || edges != 8 || io_out_ciphertext !== 4'h2 || io_fault !== 1'b0)
      $display("FAIL chk_clean: ct %h fault %b edges %0d expected ct 2 fault 0 edges 8", io_out_ciphertext, io_fault, edges);
    else n_pass++;
    tick();
    accept(4'h0, 16'h1031);
    void'(exp_q.pop_front());
    for (int unsigned c = 0; c < 3; c++) tick();
    flip = 1'b1;
    tick();
    flip = 1'b0;
    wait_valid(edges, to);
    n_total++;
    if (to || io_fault !== 1'b1 || io_out_ciphertext !== 4'h0)
      $display("FAIL chk_fault: fault %b ct %h expected fault 1 ct 0", io_fault, io_out_ciphertext);
    else n_pass++;
    tick();
    accept(4'h9, 16'h5E21);
    wait_valid(edges, to);
    exp = exp_q.pop_front();
    n_total++;
    if (to || io_fault !== 1'b0 || io_out_ciphertext !== exp)
      $display("FAIL chk_fault_clear: fault %b ct %h expected fault 0 ct %h", io_fault, io_out_ciphertext, exp);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_key();
    test_key_1031();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
`ifdef DUPLICATE_ROUND_CHECK_EN
    test_fault();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
